// File: rtl/autoconfig_pkg.sv
// rtl/autoconfig_pkg.sv - shared AutoConfig offsets, er_Type bits and board states
package autoconfig_pkg;

    // Register offsets expressed as A[6:1] (byte offset / 2)
    localparam logic [5:0] ER_TYPE_HI      = 6'h00;
    localparam logic [5:0] ER_TYPE_LO      = 6'h01;
    localparam logic [5:0] ER_PROD_HI      = 6'h02;
    localparam logic [5:0] ER_PROD_LO      = 6'h03;
    localparam logic [5:0] ER_FLAGS_HI     = 6'h04;
    localparam logic [5:0] ER_FLAGS_LO     = 6'h05;
    localparam logic [5:0] ER_MFG_FIRST    = 6'h08;
    localparam logic [5:0] ER_SERIAL_FIRST = 6'h0C;
    localparam logic [5:0] ER_SERIAL_LAST  = 6'h13;
    localparam logic [5:0] ER_ROMVEC_FIRST = 6'h14;
    localparam logic [5:0] ER_RSVD_HI      = 6'h20;
    localparam logic [5:0] ER_RSVD_LO      = 6'h21;
    localparam logic [5:0] ER_BASE_HI      = 6'h24;
    localparam logic [5:0] ER_BASE_LO      = 6'h25;
    localparam logic [5:0] ER_SHUTUP       = 6'h26;

    localparam logic [1:0] ER_TYPE_ZII          = 2'b11;
    localparam int         ER_TYPE_LINK_MEM_BIT = 5;
    localparam int         ER_TYPE_ROM_VEC_BIT  = 4;
    localparam logic [2:0] ER_SIZE_8M           = 3'b000;
    localparam logic [2:0] ER_SIZE_64K          = 3'b001;
    localparam logic [2:0] ER_SIZE_128K         = 3'b010;
    localparam logic [2:0] ER_SIZE_256K         = 3'b011;
    localparam logic [2:0] ER_SIZE_512K         = 3'b100;
    localparam logic [2:0] ER_SIZE_1M           = 3'b101;
    localparam logic [2:0] ER_SIZE_2M           = 3'b110;
    localparam logic [2:0] ER_SIZE_4M           = 3'b111;

    localparam logic [15:0] DEFAULT_MFG_ID = 16'h144A;

    typedef enum logic [1:0] {
        BS_UNCONF,
        BS_ACTIVE,
        BS_CONFIGURED,
        BS_SHUTUP
    } board_state_e;

endpackage

// File: rtl/autoconfig_er_rom.sv
// rtl/autoconfig_er_rom.sv - combinational expansion ROM nibble lookup for one board
module autoconfig_er_rom
    import autoconfig_pkg::*;
(
    input  logic [7:0]  type_byte,
    input  logic [7:0]  prod,
    input  logic [7:0]  flags,
    input  logic [15:0] mfg,
    input  logic [31:0] serial,
    input  logic [15:0] rom_vec,
    input  logic [5:0]  offset,
    output logic [3:0]  nibble
);

    logic [3:0] raw;
    logic       invert;
    logic [2:0] serial_k;

    always_comb begin
        raw      = 4'h0;
        invert   = 1'b1;
        serial_k = 3'(offset - ER_SERIAL_FIRST);
        if (offset == ER_TYPE_HI) begin
            raw    = type_byte[7:4];
            invert = 1'b0;
        end else if (offset == ER_TYPE_LO) begin
            raw    = type_byte[3:0];
            invert = 1'b0;
        end else if (offset == ER_PROD_HI) begin
            raw = prod[7:4];
        end else if (offset == ER_PROD_LO) begin
            raw = prod[3:0];
        end else if (offset == ER_FLAGS_HI) begin
            raw = flags[7:4];
        end else if (offset == ER_FLAGS_LO) begin
            raw = flags[3:0];
        end else if (offset[5:2] == ER_MFG_FIRST[5:2]) begin
            raw = 4'(mfg >> {2'd3 - offset[1:0], 2'b00});
        end else if (offset >= ER_SERIAL_FIRST && offset <= ER_SERIAL_LAST) begin
            raw = 4'(serial >> {3'd7 - serial_k, 2'b00});
        end else if (offset[5:2] == ER_ROMVEC_FIRST[5:2]) begin
            // Diag vector is only meaningful when the board advertises one
            if (type_byte[ER_TYPE_ROM_VEC_BIT])
                raw = 4'(rom_vec >> {2'd3 - offset[1:0], 2'b00});
        end else if (offset == ER_RSVD_HI || offset == ER_RSVD_LO) begin
            invert = 1'b0;
        end
        nibble = invert ? ~raw : raw;
    end

endmodule

// File: rtl/autoconfig_zii_multi.sv
// rtl/autoconfig_zii_multi.sv - Zorro II AutoConfig responder for several boards on one slot
module autoconfig_zii_multi
    import autoconfig_pkg::*;
#(
    parameter int                        NUM_BOARDS  = 2,
    parameter logic [15:0]               MFG_ID      = DEFAULT_MFG_ID,
    parameter logic [31:0]               SERIAL      = 32'h0,
    parameter logic [NUM_BOARDS*8-1:0]   ER_TYPE     = {8'hE7, 8'hD1},
    parameter logic [NUM_BOARDS*8-1:0]   ER_TYPE_ALT = {8'hE7, 8'hE0},
    parameter logic [NUM_BOARDS*8-1:0]   PROD_ID     = {8'd11, 8'd10},
    parameter logic [NUM_BOARDS*8-1:0]   ER_FLAGS    = {8'hC0, 8'hC0},
    parameter logic [NUM_BOARDS*16-1:0]  ROM_VEC     = {16'h0001, 16'h0000}
) (
    input  logic                      C7M,
    input  logic                      RESET_n,
    input  logic                      CFGIN_n,
    input  logic                      AS_n,
    input  logic                      DS_n,
    input  logic                      RW_n,
    input  logic [7:0]                A_HIGH,
    input  logic [5:0]                A_LOW,
    input  logic [3:0]                D_IN,
    input  logic [NUM_BOARDS-1:0]     SIZE_ALT,
    output logic [3:0]                D_OUT,
    output logic [3:0]                D_OE,
    output logic [NUM_BOARDS*8-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
    output logic                      CFGOUT_n
);

    localparam logic [2:0] NB = 3'(NUM_BOARDS);

    board_state_e state_q [NUM_BOARDS];
    board_state_e state_d [NUM_BOARDS];
    logic [2:0]  idx_q;
    logic [3:0]  pend_lo_q;
    logic        done_q;
    logic [1:0]  as_sync_q;
    logic        as_idle;
    logic        access, rd_cycle, wr_fire, advance, cur_term;
    logic [7:0]  cur_type, cur_prod, cur_flags;
    logic [15:0] cur_vec;
    logic [3:0]  rom_nibble;

    // Both synchroniser stages high: AS_n has really been released, not a stale sample
    assign as_idle = &as_sync_q;

    always_comb begin
        access    = !CFGIN_n && CFGOUT_n && (A_HIGH == 8'hE8) && !AS_n;
        rd_cycle  = access && !DS_n && RW_n;
        cur_type  = ER_TYPE[7:0];
        cur_prod  = PROD_ID[7:0];
        cur_flags = ER_FLAGS[7:0];
        cur_vec   = ROM_VEC[15:0];
        cur_term  = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_type  = SIZE_ALT[i] ? ER_TYPE_ALT[i*8 +: 8] : ER_TYPE[i*8 +: 8];
                cur_prod  = PROD_ID[i*8 +: 8];
                cur_flags = ER_FLAGS[i*8 +: 8];
                cur_vec   = ROM_VEC[i*16 +: 16];
                cur_term  = (state_q[i] == BS_CONFIGURED) || (state_q[i] == BS_SHUTUP);
            end
        end
        wr_fire = access && !DS_n && !RW_n && !done_q && !cur_term;
        advance = as_idle && cur_term && CFGOUT_n;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            state_d[i] = state_q[i];
            if (idx_q == 3'(i)) begin
                if (state_q[i] == BS_UNCONF)
                    state_d[i] = BS_ACTIVE;
                if (wr_fire && A_LOW == ER_BASE_HI)
                    state_d[i] = BS_CONFIGURED;
                else if (wr_fire && A_LOW == ER_SHUTUP)
                    state_d[i] = BS_SHUTUP;
            end
        end
    end

    assign D_OE = rd_cycle ? 4'hF : 4'h0;

    autoconfig_er_rom u_rom (
        .type_byte (cur_type),
        .prod      (cur_prod),
        .flags     (cur_flags),
        .mfg       (MFG_ID),
        .serial    (SERIAL),
        .rom_vec   (cur_vec),
        .offset    (A_LOW),
        .nibble    (rom_nibble)
    );

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            D_OUT        <= 4'hF;
            BASE         <= '0;
            CONFIGURED_n <= '1;
            CFGOUT_n     <= 1'b1;
            idx_q        <= 3'd0;
            pend_lo_q    <= 4'h0;
            done_q       <= 1'b0;
            as_sync_q    <= 2'b11;
            for (int i = 0; i < NUM_BOARDS; i++)
                state_q[i] <= BS_UNCONF;
        end else begin
            as_sync_q <= {as_sync_q[0], AS_n};
            for (int i = 0; i < NUM_BOARDS; i++)
                state_q[i] <= state_d[i];
            if (wr_fire)
                done_q <= 1'b1;
            else if (as_idle)
                done_q <= 1'b0;
            if (rd_cycle)
                D_OUT <= rom_nibble;
            if (wr_fire && A_LOW == ER_BASE_LO)
                pend_lo_q <= D_IN;
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (idx_q == 3'(i) && wr_fire && A_LOW == ER_BASE_HI) begin
                    BASE[i*8 +: 8]  <= {D_IN, pend_lo_q};
                    CONFIGURED_n[i] <= 1'b0;
                end
            end
            if (advance) begin
                idx_q     <= idx_q + 3'd1;
                pend_lo_q <= 4'h0;
                if (idx_q + 3'd1 == NB)
                    CFGOUT_n <= 1'b0;
            end
        end
    end

endmodule
